// File: rtl/udma_l2_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : udma_l2_responder                                             |
// | Purpose  : Memory-side responder for the uDMA L2 ports. Serves the      |
// |            read-only (ro) and write-only (wo) TCDM-style initiator ports |
// |            (req/gnt/rvalid) from a single single-port SRAM macro with    |
// |            round-robin arbitration and a fixed-latency response pipe.    |
// | Ports    : sys_clk_i / sys_rst_ni      clock, async active-low reset     |
// |            L2_ro_* / L2_wo_*           initiator ports (req, wen, addr,  |
// |                                        be, wdata in; gnt, rvalid, rdata) |
// |            mem_*                       SRAM macro interface              |
// |            err_cnt_o                   out-of-range access counter       |
// | Options  : UDMA_L2_RANGE_CHECK_EN - when defined, accesses outside the   |
// |            SRAM window are granted but not forwarded to the SRAM; reads  |
// |            return 0xDEAD_BEEF and err_cnt_o counts them (saturating).    |
// |            When undefined the address aliases and err_cnt_o is 0.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module udma_l2_responder #(
  parameter int unsigned L2_DATA_WIDTH  = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 15,
  parameter int unsigned MEM_LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR      = 32'h1C00_0000
) (
  input  logic                         sys_clk_i,
  input  logic                         sys_rst_ni,

  input  logic                         L2_ro_req_i,
  input  logic                         L2_ro_wen_i,
  input  logic [31:0]                  L2_ro_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0]   L2_ro_be_i,
  input  logic [L2_DATA_WIDTH-1:0]     L2_ro_wdata_i,
  output logic                         L2_ro_gnt_o,
  output logic                         L2_ro_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]     L2_ro_rdata_o,

  input  logic                         L2_wo_req_i,
  input  logic                         L2_wo_wen_i,
  input  logic [31:0]                  L2_wo_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0]   L2_wo_be_i,
  input  logic [L2_DATA_WIDTH-1:0]     L2_wo_wdata_i,
  output logic                         L2_wo_gnt_o,
  output logic                         L2_wo_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]     L2_wo_rdata_o,

  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0]    mem_addr_o,
  output logic [L2_DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [L2_DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [L2_DATA_WIDTH-1:0]     mem_rdata_i,

  output logic [15:0]                  err_cnt_o
);

  localparam int unsigned BE_WIDTH = L2_DATA_WIDTH / 8;
  localparam logic [L2_DATA_WIDTH-1:0] ERR_RDATA = L2_DATA_WIDTH'(32'hDEAD_BEEF);

  // Port identity doubles as the round-robin priority pointer.
  typedef enum logic {
    PORT_RO = 1'b0,
    PORT_WO = 1'b1
  } port_e;

  // One response-pipe entry per granted access.
  typedef struct packed {
    logic  valid;
    port_e port;
    logic  is_read;
    logic  err;
  } resp_t;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  port_e rr_q, rr_d;
  logic  ro_gnt, wo_gnt, any_gnt;

  always_comb begin
    ro_gnt = 1'b0;
    wo_gnt = 1'b0;
    rr_d   = rr_q;
    // Grants are suppressed while reset is asserted even though the
    // request path itself is purely combinational.
    if (sys_rst_ni) begin
      if (L2_ro_req_i && L2_wo_req_i) begin
        if (rr_q == PORT_RO) begin
          ro_gnt = 1'b1;
          rr_d   = PORT_WO;
        end else begin
          wo_gnt = 1'b1;
          rr_d   = PORT_RO;
        end
      end else begin
        // A lone requester wins without moving the pointer.
        ro_gnt = L2_ro_req_i;
        wo_gnt = L2_wo_req_i;
      end
    end
  end

  assign any_gnt = ro_gnt | wo_gnt;

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      rr_q <= PORT_RO;
    end else begin
      rr_q <= rr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request mux and address translation
  // ---------------------------------------------------------------------------
  port_e                     sel_port;
  logic                      sel_wen;
  logic [31:0]               sel_addr;
  logic [BE_WIDTH-1:0]       sel_be;
  logic [L2_DATA_WIDTH-1:0]  sel_wdata;
  logic [31:0]               offset;
  logic                      out_of_range;

  always_comb begin
    sel_port  = wo_gnt ? PORT_WO : PORT_RO;
    sel_wen   = wo_gnt ? L2_wo_wen_i   : L2_ro_wen_i;
    sel_addr  = wo_gnt ? L2_wo_addr_i  : L2_ro_addr_i;
    sel_be    = wo_gnt ? L2_wo_be_i    : L2_ro_be_i;
    sel_wdata = wo_gnt ? L2_wo_wdata_i : L2_ro_wdata_i;
  end

  // Byte offset into the SRAM window; the two LSBs select a byte within the
  // word and are dropped when forming the word address.
  assign offset = sel_addr - BASE_ADDR;

`ifdef UDMA_L2_RANGE_CHECK_EN
  logic addr_below;
  logic addr_above;

  assign addr_below   = (sel_addr < BASE_ADDR);
  assign addr_above   = ((offset >> (MEM_ADDR_WIDTH + 2)) != 32'd0);
  assign out_of_range = addr_below | addr_above;
`else
  // No window check: upper offset bits are discarded and the access aliases.
  assign out_of_range = 1'b0;
`endif

  // Offset bits outside the word-address field carry no information here.
  logic unused_offset;
  assign unused_offset = ^offset;

  assign mem_req_o   = any_gnt & ~out_of_range;
  assign mem_we_o    = ~sel_wen;
  assign mem_addr_o  = offset[MEM_ADDR_WIDTH+1:2];
  assign mem_be_o    = sel_be;
  assign mem_wdata_o = sel_wdata;

  // ---------------------------------------------------------------------------
  // Response pipe: entry enters at index 0 in the grant cycle and reaches the
  // top index MEM_LATENCY cycles later, lining up with mem_rdata_i.
  // ---------------------------------------------------------------------------
  resp_t                    pipe_in;
  resp_t [MEM_LATENCY-1:0]  pipe_q;
  resp_t [MEM_LATENCY-1:0]  pipe_d;
  resp_t                    resp;

  always_comb begin
    pipe_in         = '0;
    pipe_in.valid   = any_gnt;
    pipe_in.port    = sel_port;
    pipe_in.is_read = sel_wen;
    pipe_in.err     = out_of_range;
  end

  if (MEM_LATENCY == 1) begin : g_pipe_single
    always_comb begin
      pipe_d    = '0;
      pipe_d[0] = pipe_in;
    end
  end else begin : g_pipe_shift
    always_comb begin
      pipe_d = {pipe_q[MEM_LATENCY-2:0], pipe_in};
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign resp = pipe_q[MEM_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Response routing: rdata is zero outside the owning port's rvalid cycle.
  // ---------------------------------------------------------------------------
  logic [L2_DATA_WIDTH-1:0] resp_rdata;

  always_comb begin
    resp_rdata = '0;
    if (resp.valid && resp.is_read) begin
      resp_rdata = resp.err ? ERR_RDATA : mem_rdata_i;
    end
  end

  always_comb begin
    L2_ro_rvalid_o = resp.valid && (resp.port == PORT_RO);
    L2_wo_rvalid_o = resp.valid && (resp.port == PORT_WO);
    L2_ro_rdata_o  = L2_ro_rvalid_o ? resp_rdata : '0;
    L2_wo_rdata_o  = L2_wo_rvalid_o ? resp_rdata : '0;
  end

  assign L2_ro_gnt_o = ro_gnt;
  assign L2_wo_gnt_o = wo_gnt;

  // ---------------------------------------------------------------------------
  // Error counter
  // ---------------------------------------------------------------------------
`ifdef UDMA_L2_RANGE_CHECK_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (any_gnt && out_of_range && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_udma_l2_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_udma_l2_responder                                          |
// | Purpose  : Scoreboard bench for udma_l2_responder. Two instances (read   |
// |            latency 1 and 2) see identical stimulus, each backed by its   |
// |            own SRAM model. Expected responses are queued at grant time   |
// |            and popped by per-instance monitors on rvalid.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_udma_l2_responder;

  localparam bit P_RO = 1'b0;
  localparam bit P_WO = 1'b1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ro_req, ro_wen, wo_req, wo_wen;
  logic [31:0] ro_addr, ro_wdata, wo_addr, wo_wdata;
  logic [3:0]  ro_be, wo_be;

  logic        a_ro_gnt, a_ro_rvalid, a_wo_gnt, a_wo_rvalid;
  logic [31:0] a_ro_rdata, a_wo_rdata, a_mem_wdata, a_mem_rdata;
  logic        a_mem_req, a_mem_we;
  logic [14:0] a_mem_addr;
  logic [3:0]  a_mem_be;
  logic [15:0] a_err_cnt;

  logic        b_ro_gnt, b_ro_rvalid, b_wo_gnt, b_wo_rvalid;
  logic [31:0] b_ro_rdata, b_wo_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_mem_req, b_mem_we;
  logic [14:0] b_mem_addr;
  logic [3:0]  b_mem_be;
  logic [15:0] b_err_cnt;

  udma_l2_responder #(.MEM_LATENCY(1)) u_dut_a (
    .sys_clk_i(clk), .sys_rst_ni(rst_n),
    .L2_ro_req_i(ro_req), .L2_ro_wen_i(ro_wen), .L2_ro_addr_i(ro_addr),
    .L2_ro_be_i(ro_be), .L2_ro_wdata_i(ro_wdata), .L2_ro_gnt_o(a_ro_gnt),
    .L2_ro_rvalid_o(a_ro_rvalid), .L2_ro_rdata_o(a_ro_rdata),
    .L2_wo_req_i(wo_req), .L2_wo_wen_i(wo_wen), .L2_wo_addr_i(wo_addr),
    .L2_wo_be_i(wo_be), .L2_wo_wdata_i(wo_wdata), .L2_wo_gnt_o(a_wo_gnt),
    .L2_wo_rvalid_o(a_wo_rvalid), .L2_wo_rdata_o(a_wo_rdata),
    .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
    .mem_be_o(a_mem_be), .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata),
    .err_cnt_o(a_err_cnt)
  );

  udma_l2_responder #(.MEM_LATENCY(2)) u_dut_b (
    .sys_clk_i(clk), .sys_rst_ni(rst_n),
    .L2_ro_req_i(ro_req), .L2_ro_wen_i(ro_wen), .L2_ro_addr_i(ro_addr),
    .L2_ro_be_i(ro_be), .L2_ro_wdata_i(ro_wdata), .L2_ro_gnt_o(b_ro_gnt),
    .L2_ro_rvalid_o(b_ro_rvalid), .L2_ro_rdata_o(b_ro_rdata),
    .L2_wo_req_i(wo_req), .L2_wo_wen_i(wo_wen), .L2_wo_addr_i(wo_addr),
    .L2_wo_be_i(wo_be), .L2_wo_wdata_i(wo_wdata), .L2_wo_gnt_o(b_wo_gnt),
    .L2_wo_rvalid_o(b_wo_rvalid), .L2_wo_rdata_o(b_wo_rdata),
    .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
    .mem_be_o(b_mem_be), .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata),
    .err_cnt_o(b_err_cnt)
  );

  // SRAM models: word i preloaded with 0xA5A5_0000 | i.
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] a_rd1, b_rd1, b_rd2;

  always @(posedge clk) begin
    if (a_mem_req) begin
      if (a_mem_we) begin
        for (int k = 0; k < 4; k++)
          if (a_mem_be[k]) mem_a[a_mem_addr[7:0]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
      end else begin
        a_rd1 <= mem_a[a_mem_addr[7:0]];
      end
    end
  end

  always @(posedge clk) begin
    if (b_mem_req) begin
      if (b_mem_we) begin
        for (int k = 0; k < 4; k++)
          if (b_mem_be[k]) mem_b[b_mem_addr[7:0]][8*k +: 8] <= b_mem_wdata[8*k +: 8];
      end else begin
        b_rd1 <= mem_b[b_mem_addr[7:0]];
      end
    end
    b_rd2 <= b_rd1;
  end

  assign a_mem_rdata = a_rd1;
  assign b_mem_rdata = b_rd2;

  // Scoreboard
  typedef struct {
    bit          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input bit port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    e.cyc  = cyc;
    qa.push_back(e);
    qb.push_back(e);
  endtask

  task automatic unexpected(input string tag, input logic rv, input logic wv);
    total++;
    bad++;
    $display("FAIL %s_unexpected_rvalid: got ro=%0b wo=%0b expected no response", tag, rv, wv);
  endtask

  task automatic cmp_resp(input string tag, input int lat, input exp_t e,
                          input logic rv, input logic wv,
                          input logic [31:0] rd, input logic [31:0] wd);
    check({tag, "_rvalid_route"}, {30'd0, rv, wv}, e.port ? 32'd1 : 32'd2);
    check({tag, "_rdata"}, e.port ? wd : rd, e.data);
    check({tag, "_other_rdata"}, e.port ? rd : wd, 32'd0);
    check({tag, "_latency"}, cyc, e.cyc + lat);
  endtask

  always @(negedge clk) begin
    if (rst_n && (a_ro_rvalid || a_wo_rvalid)) begin
      if (qa.size() == 0) unexpected("A", a_ro_rvalid, a_wo_rvalid);
      else cmp_resp("A", 1, qa.pop_front(), a_ro_rvalid, a_wo_rvalid, a_ro_rdata, a_wo_rdata);
    end
  end

  always @(negedge clk) begin
    if (rst_n && (b_ro_rvalid || b_wo_rvalid)) begin
      if (qb.size() == 0) unexpected("B", b_ro_rvalid, b_wo_rvalid);
      else cmp_resp("B", 2, qb.pop_front(), b_ro_rvalid, b_wo_rvalid, b_ro_rdata, b_wo_rdata);
    end
  end

  // Stimulus helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ro_req = 0; ro_wen = 1; ro_addr = 0; ro_be = 4'hF; ro_wdata = 0;
    wo_req = 0; wo_wen = 1; wo_addr = 0; wo_be = 4'hF; wo_wdata = 0;
  endtask

  task automatic ro_rd(input logic [31:0] addr);
    ro_req = 1; ro_wen = 1; ro_addr = addr; ro_be = 4'hF; ro_wdata = 0;
  endtask

  task automatic wo_rd(input logic [31:0] addr);
    wo_req = 1; wo_wen = 1; wo_addr = addr; wo_be = 4'hF; wo_wdata = 0;
  endtask

  task automatic chk_gnt(input string name, input logic ro_g, input logic wo_g);
    check({name, "_gnt_a"}, {30'd0, a_ro_gnt, a_wo_gnt}, {30'd0, ro_g, wo_g});
    check({name, "_gnt_b"}, {30'd0, b_ro_gnt, b_wo_gnt}, {30'd0, ro_g, wo_g});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'hA5A5_0000 | i;
      mem_b[i] = 32'hA5A5_0000 | i;
    end
    a_rd1 = 0; b_rd1 = 0; b_rd2 = 0;
    idle();

    // Held in reset with a pending request: no grant, no SRAM strobe.
    ro_rd(32'h1C00_0000);
    step();
    @(negedge clk);
    chk_gnt("in_reset", 0, 0);
    check("in_reset_mem_req", {30'd0, a_mem_req, b_mem_req}, 32'd0);
    check("reset_rvalid", {28'd0, a_ro_rvalid, a_wo_rvalid, b_ro_rvalid, b_wo_rvalid}, 32'd0);
    check("reset_rdata", a_ro_rdata | a_wo_rdata | b_ro_rdata | b_wo_rdata, 32'd0);
    check("reset_err_cnt", {a_err_cnt, b_err_cnt}, 32'd0);
    step();
    rst_n = 1;

    // Round-robin: first both-request goes to ro, then wo; next contention to wo.
    ro_rd(32'h1C00_0004);
    wo_rd(32'h1C00_0008);
    @(negedge clk);
    chk_gnt("rr1", 1, 0);
    check("rr1_addr", {17'd0, a_mem_addr}, 32'd1);
    expect_resp(P_RO, 32'hA5A5_0001);
    step();
    ro_req = 0;
    @(negedge clk);
    chk_gnt("rr2", 0, 1);
    check("rr2_addr", {17'd0, b_mem_addr}, 32'd2);
    expect_resp(P_WO, 32'hA5A5_0002);
    step();
    ro_rd(32'h1C00_000C);
    wo_rd(32'h1C00_0014);
    @(negedge clk);
    chk_gnt("rr3", 0, 1);
    expect_resp(P_WO, 32'hA5A5_0005);
    step();
    wo_req = 0;
    @(negedge clk);
    chk_gnt("rr4", 1, 0);
    expect_resp(P_RO, 32'hA5A5_0003);
    step();
    idle();

    // Simple ro read of word 4.
    ro_rd(32'h1C00_0010);
    @(negedge clk);
    chk_gnt("rd4", 1, 0);
    check("rd4_mem", {a_mem_req, a_mem_we, 15'd0, a_mem_addr}, {1'b1, 1'b0, 15'd0, 15'd4});
    expect_resp(P_RO, 32'hA5A5_0004);
    step();
    idle();
    repeat (3) step();

    // Partial write through wo, then read back through ro.
    wo_req = 1; wo_wen = 0; wo_addr = 32'h1C00_0020; wo_be = 4'b0011; wo_wdata = 32'h1234_5678;
    @(negedge clk);
    chk_gnt("wr8", 0, 1);
    check("wr8_mem", {a_mem_req, a_mem_we, 11'd0, a_mem_be, a_mem_addr}, {1'b1, 1'b1, 11'd0, 4'b0011, 15'd8});
    check("wr8_wdata", a_mem_wdata, 32'h1234_5678);
    check("wr8_we_b", {31'd0, b_mem_we}, 32'd1);
    expect_resp(P_WO, 32'h0);
    step();
    idle();
    ro_rd(32'h1C00_0020);
    @(negedge clk);
    chk_gnt("rb8", 1, 0);
    expect_resp(P_RO, 32'hA5A5_5678);
    step();
    idle();
    repeat (3) step();

    // Eight back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      ro_rd(32'h1C00_0000 + 4 * i);
      @(negedge clk);
      chk_gnt($sformatf("b2b%0d", i), 1, 0);
      check($sformatf("b2b%0d_addr", i), {17'd0, b_mem_addr}, i);
      expect_resp(P_RO, 32'hA5A5_0000 | i);
      step();
    end
    idle();
    repeat (4) step();

    // Window boundaries: last valid word, first word past the end, below base.
    ro_rd(32'h1C01_FFFC);
    @(negedge clk);
    check("top_word_req", {30'd0, a_mem_req, b_mem_req}, 32'd3);
    check("top_word_addr", {17'd0, a_mem_addr}, 32'h7FFF);
    expect_resp(P_RO, 32'hA5A5_00FF);
    step();
    ro_rd(32'h1C02_0000);
    @(negedge clk);
    chk_gnt("past_end", 1, 0);
`ifdef UDMA_L2_RANGE_CHECK_EN
    check("past_end_req", {30'd0, a_mem_req, b_mem_req}, 32'd0);
    expect_resp(P_RO, 32'hDEAD_BEEF);
`else
    check("past_end_req", {30'd0, a_mem_req, b_mem_req}, 32'd3);
    expect_resp(P_RO, 32'hA5A5_0000);
`endif
    step();
    ro_rd(32'h1000_0000);
    @(negedge clk);
    chk_gnt("below_base", 1, 0);
    check("below_base_addr", {17'd0, a_mem_addr}, 32'd0);
`ifdef UDMA_L2_RANGE_CHECK_EN
    check("below_base_req", {30'd0, a_mem_req, b_mem_req}, 32'd0);
    expect_resp(P_RO, 32'hDEAD_BEEF);
`else
    check("below_base_req", {30'd0, a_mem_req, b_mem_req}, 32'd3);
    expect_resp(P_RO, 32'hA5A5_0000);
`endif
    step();
    idle();
    @(negedge clk);
`ifdef UDMA_L2_RANGE_CHECK_EN
    check("err_cnt", {a_err_cnt, b_err_cnt}, {16'd2, 16'd2});
`else
    check("err_cnt", {a_err_cnt, b_err_cnt}, 32'd0);
`endif
    repeat (4) step();

    // Reset the cycle after a grant: the granted read must never respond and
    // the pointer must return to ro.
    ro_rd(32'h1C00_000C);
    wo_rd(32'h1C00_0010);
    @(negedge clk);
    chk_gnt("pre_rst", 1, 0);
    step();
    rst_n = 0;
    @(negedge clk);
    chk_gnt("mid_rst", 0, 0);
    check("mid_rst_mem_req", {30'd0, a_mem_req, b_mem_req}, 32'd0);
    step();
    rst_n = 1;
    idle();
    repeat (4) step();
    check("post_rst_err_cnt", {a_err_cnt, b_err_cnt}, 32'd0);
    ro_rd(32'h1C00_0018);
    wo_rd(32'h1C00_001C);
    @(negedge clk);
    chk_gnt("post_rst_rr", 1, 0);
    expect_resp(P_RO, 32'hA5A5_0006);
    step();
    ro_req = 0;
    @(negedge clk);
    chk_gnt("post_rst_rr2", 0, 1);
    expect_resp(P_WO, 32'hA5A5_0007);
    step();
    idle();
    repeat (5) step();

    check("drain_a", qa.size(), 32'd0);
    check("drain_b", qb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
